// File: rtl/tt_ctrl_seq.sv
// Mux control sequencer: on an accepted request, drives the timed select-reset and
// increment pulse train to reach the target project address, then restores ctrl_ena.
module tt_ctrl_seq #(
    parameter int ADDR_W = 10,
    parameter int T_HALF = 2,
    parameter int T_RST  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_ena,
    input  logic              req_full,
    output logic              req_ready,
    output logic              done,
    output logic [ADDR_W-1:0] cur_addr,
    output logic              cur_valid,
    output logic              ctrl_sel_rst_n,
    output logic              ctrl_sel_inc,
    output logic              ctrl_ena
);

    typedef enum logic [2:0] {IDLE, DIS, RST, GAP, INC_HI, INC_LO, FIN} state_t;

    localparam int TW = 16;
    localparam logic [TW-1:0] HALF_T = TW'(T_HALF - 1);
    localparam logic [TW-1:0] RST_T  = TW'(T_RST - 1);

    state_t            state_reg, state_next;
    logic [TW-1:0]     timer_reg, timer_next;
    logic [ADDR_W-1:0] cnt_reg, cnt_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic              ena_lat_reg, ena_lat_next;
    logic              full_reg, full_next;

    logic              ready_reg, ready_next;
    logic              done_reg, done_next;
    logic [ADDR_W-1:0] cur_addr_reg, cur_addr_next;
    logic              cur_valid_reg, cur_valid_next;
    logic              rst_n_reg, rst_n_next;
    logic              inc_reg, inc_next;
    logic              ena_reg, ena_next;

    always_comb begin
        state_next   = state_reg;
        timer_next   = timer_reg;
        cnt_next     = cnt_reg;
        addr_next    = addr_reg;
        ena_lat_next = ena_lat_reg;
        full_next    = full_reg;

        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    addr_next    = req_addr;
                    ena_lat_next = req_ena;
                    // Forward moves from a known address skip the full reset.
                    if (cur_valid_reg && !req_full && req_addr >= cur_addr_reg) begin
                        full_next = 1'b0;
                        cnt_next  = req_addr - cur_addr_reg;
                    end else begin
                        full_next = 1'b1;
                        cnt_next  = req_addr;
                    end
                    state_next = DIS;
                    timer_next = HALF_T;
                end
            end
            DIS: begin
                if (timer_reg != '0) begin
                    timer_next = timer_reg - 1'b1;
                end else if (full_reg) begin
                    state_next = RST;
                    timer_next = RST_T;
                end else if (cnt_reg != '0) begin
                    state_next = INC_HI;
                    timer_next = HALF_T;
                end else begin
                    state_next = FIN;
                end
            end
            RST: begin
                if (timer_reg != '0) begin
                    timer_next = timer_reg - 1'b1;
                end else begin
                    state_next = GAP;
                    timer_next = HALF_T;
                end
            end
            GAP: begin
                if (timer_reg != '0) begin
                    timer_next = timer_reg - 1'b1;
                end else if (cnt_reg != '0) begin
                    state_next = INC_HI;
                    timer_next = HALF_T;
                end else begin
                    state_next = FIN;
                end
            end
            INC_HI: begin
                if (timer_reg != '0) begin
                    timer_next = timer_reg - 1'b1;
                end else begin
                    state_next = INC_LO;
                    timer_next = HALF_T;
                end
            end
            INC_LO: begin
                if (timer_reg != '0) begin
                    timer_next = timer_reg - 1'b1;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                    if (cnt_reg == ADDR_W'(1)) begin
                        state_next = FIN;
                    end else begin
                        state_next = INC_HI;
                        timer_next = HALF_T;
                    end
                end
            end
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they change on the state's first cycle.
    always_comb begin
        ready_next     = (state_next == IDLE);
        done_next      = (state_next == FIN);
        inc_next       = (state_next == INC_HI);
        rst_n_next     = rst_n_reg;
        ena_next       = ena_reg;
        cur_addr_next  = cur_addr_reg;
        cur_valid_next = cur_valid_reg;
        case (state_next)
            DIS:     ena_next   = 1'b0;
            RST:     rst_n_next = 1'b0;
            GAP:     rst_n_next = 1'b1;
            FIN: begin
                ena_next       = ena_lat_reg;
                cur_addr_next  = addr_reg;
                cur_valid_next = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            timer_reg     <= '0;
            cnt_reg       <= '0;
            addr_reg      <= '0;
            ena_lat_reg   <= 1'b0;
            full_reg      <= 1'b1;
            ready_reg     <= 1'b1;
            done_reg      <= 1'b0;
            cur_addr_reg  <= '0;
            cur_valid_reg <= 1'b0;
            rst_n_reg     <= 1'b0;
            inc_reg       <= 1'b0;
            ena_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            timer_reg     <= timer_next;
            cnt_reg       <= cnt_next;
            addr_reg      <= addr_next;
            ena_lat_reg   <= ena_lat_next;
            full_reg      <= full_next;
            ready_reg     <= ready_next;
            done_reg      <= done_next;
            cur_addr_reg  <= cur_addr_next;
            cur_valid_reg <= cur_valid_next;
            rst_n_reg     <= rst_n_next;
            inc_reg       <= inc_next;
            ena_reg       <= ena_next;
        end
    end

    assign req_ready      = ready_reg;
    assign done           = done_reg;
    assign cur_addr       = cur_addr_reg;
    assign cur_valid      = cur_valid_reg;
    assign ctrl_sel_rst_n = rst_n_reg;
    assign ctrl_sel_inc   = inc_reg;
    assign ctrl_ena       = ena_reg;

endmodule

// File: doc/tt_ctrl_seq.md
Name: tt_ctrl_seq

Overview:
- Sequencer that drives the mux control interface (ctrl_sel_rst_n, ctrl_sel_inc, ctrl_ena) so that one user project address is selected and enabled.
- A requester submits a target address through a valid/ready handshake. The block generates the timed reset and increment pulse train, then raises ctrl_ena.
- It tracks the currently selected address. Forward moves use only the increment pulses and skip the full reset.
- Sits between the board/host control logic (or an on-chip config FSM) and the tt_ctrl control pins.

Parameters:
- ADDR_W, 10, width of the project address and of the pulse counter.
- T_HALF, 2, cycles per half-phase. Used for the increment-pulse high and low halves, the disable phase and the post-reset gap. Minimum 1.
- T_RST, 4, cycles ctrl_sel_rst_n is held low in a full reset. Minimum 1.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- req_valid  input  1  request present.
- req_addr  input  ADDR_W  target project address.
- req_ena  input  1  final ctrl_ena level after selection.
- req_full  input  1  force the full reset path, even when incremental is possible.
- req_ready  output  1  block idle; a request is accepted when req_valid & req_ready.
- done  output  1  one-cycle pulse when the sequence completes.
- cur_addr  output  ADDR_W  address currently selected.
- cur_valid  output  1  cur_addr is known (at least one sequence has completed since reset).
- ctrl_sel_rst_n  output  1  mux select-counter reset, active low.
- ctrl_sel_inc  output  1  mux select-counter increment pulse.
- ctrl_ena  output  1  mux enable.

Behaviour:
- One clock, reset synchronous and active-high. All outputs are registered.
- Reset values: ctrl_sel_rst_n=0, ctrl_sel_inc=0, ctrl_ena=0, done=0, cur_addr=0, cur_valid=0, req_ready=1 (IDLE).
- States: IDLE, DIS, RST, GAP, INC_HI, INC_LO, FIN.
- IDLE:
  - req_ready=1; control outputs hold their last values.
  - On acceptance, latch req_addr/req_ena. Choose the mode:
    - incremental if cur_valid & !req_full & req_addr>=cur_addr;
    - otherwise full.
  - Load cnt = req_addr-cur_addr (incremental) or req_addr (full). Go to DIS. req_ready=0 from the next cycle.
- DIS:
  - ctrl_ena=0 for T_HALF cycles.
  - Then go to RST (full), INC_HI (incremental with cnt>0), or FIN (cnt==0).
- RST: ctrl_sel_rst_n=0 for T_RST cycles, then go to GAP.
- GAP:
  - ctrl_sel_rst_n=1 for T_HALF cycles. This guarantees no increment edge coincides with reset release.
  - Then go to INC_HI if cnt>0, else FIN.
- INC_HI: ctrl_sel_inc=1 for T_HALF cycles.
- INC_LO:
  - ctrl_sel_inc=0 for T_HALF cycles.
  - cnt decrements once per pulse.
  - When cnt reaches 0, go to FIN; else return to INC_HI.
- FIN (one cycle):
  - ctrl_ena=latched req_ena, done=1.
  - cur_addr=latched addr, cur_valid=1.
  - Next state IDLE.
- Phase timing: each phase timer is exact. Output changes are visible on the first cycle of the new state.
- Full latency, acceptance edge at cycle 0: DIS 1..T_HALF, RST, GAP, then cnt×2×T_HALF. FIN/done falls on cycle T_HALF+T_RST+T_HALF+2·T_HALF·cnt+1.
- Incremental latency: FIN on cycle T_HALF+2·T_HALF·cnt+1.
- Same address, incremental (cnt=0): ena dropped for T_HALF cycles, then FIN. This acts as a project re-enable.
- Backward move (req_addr<cur_addr): always uses the full path.
- Width: cnt is ADDR_W bits, so the max address is 2^ADDR_W-1. No wrap-around; the subtraction is only used when req_addr>=cur_addr.
- Requests: req_valid while busy is ignored (not queued); the requester must hold it until req_ready. Inputs are sampled only at acceptance.
- ctrl_sel_inc is never high while ctrl_sel_rst_n=0 or while ctrl_ena=1.
- Reset mid-sequence: all state returns to reset values next cycle. cur_valid=0, so the next request always takes the full path.

Test Plan:
- Reset, then req addr=3, ena=1 (T_HALF=2, T_RST=4) -> rst_n low on cycles 3–6; exactly 3 inc pulses, each 2 cycles high and 2 low, starting cycle 9; done and ctrl_ena=1 on cycle 21; cur_addr=3.
- From cur_addr=3, req addr=5 -> no rst_n low; 2 inc pulses; done on cycle 11; cur_addr=5.
- From cur_addr=5, req addr=2 -> full path with 2 pulses; done on cycle 17; req_full=1 with addr=7 also takes the full path.
- Req addr=5 while cur_addr=5, ena=0 -> ena low from cycle 1; no rst/inc activity; done on cycle 3 with ctrl_ena=0.
- Assert rst during the second INC_HI -> next cycle rst_n=0, inc=0, ena=0, cur_valid=0; a following req addr=1 takes the full path.
- Hold req_valid with changing addr while busy -> ignored until req_ready=1. Invariant checker throughout: inc never high while rst_n=0 or ena=1; done width is 1 cycle.
